// File: rtl/fp_norm_pkg.sv
// rtl/fp_norm_pkg.sv - shared widths, constants and result record for the post-add normalizer
package fp_norm_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int SIG_W  = FRAC_W + 2;

    localparam logic [EXP_W-1:0] EXP_INF = 8'hFF;

    typedef struct packed {
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
        logic              zero;
        logic              ovf;
        logic              unf;
    } norm_t;

endpackage

// File: rtl/fp_norm_lzc24.sv
// rtl/fp_norm_lzc24.sv - combinational 24-bit leading-zero counter (module lzc24)
module lzc24 (
    input  logic [23:0] data,
    output logic [4:0]  count,
    output logic        zero
);

    // Ascending scan: the highest set bit is the last one to write count.
    always_comb begin
        count = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (data[i]) begin
                count = 5'(23 - i);
            end
        end
        zero = (data == 24'd0);
    end

endmodule

// File: rtl/fp_norm.sv
// rtl/fp_norm.sv - registered post-addition normalizer; FP_NORM_ROUND_EN enables round-to-nearest-even on carry
module fp_norm
    import fp_norm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [EXP_W-1:0]  exp_max,
    input  logic [SIG_W-1:0]  fraction_25,
    output logic              out_valid,
    output logic [EXP_W-1:0]  exp_out,
    output logic [FRAC_W-1:0] fraction_out,
    output logic              zero_out,
    output logic              ovf_out,
    output logic              unf_out
);

    logic [4:0]       lz;
    logic             all_zero;
    logic             round_up;
    logic [FRAC_W:0]  frac_rnd;
    logic [EXP_W:0]   exp_carry;
    logic [FRAC_W:0]  frac_shift;
    logic [EXP_W-1:0] shift_ext;
    norm_t            nxt;
    norm_t            res_q;

    lzc24 u_lzc (
        .data  (fraction_25[FRAC_W:0]),
        .count (lz),
        .zero  (all_zero)
    );

    always_comb begin
`ifdef FP_NORM_ROUND_EN
        // The single shifted-out bit can only be zero or exactly half an ulp.
        round_up = fraction_25[0] & fraction_25[1];
`else
        round_up = 1'b0;
`endif
        frac_rnd   = {1'b0, fraction_25[FRAC_W:1]} + {{FRAC_W{1'b0}}, round_up};
        exp_carry  = {1'b0, exp_max} + (EXP_W+1)'(1) + {{EXP_W{1'b0}}, frac_rnd[FRAC_W]};
        frac_shift = fraction_25[FRAC_W:0] << lz;
        shift_ext  = EXP_W'(lz);

        nxt = '0;
        if (fraction_25[SIG_W-1]) begin
            if (exp_carry >= {1'b0, EXP_INF}) begin
                nxt.exp = EXP_INF;
                nxt.ovf = 1'b1;
            end else begin
                nxt.exp  = exp_carry[EXP_W-1:0];
                // A rounding carry-out leaves frac_rnd[FRAC_W-1:0] all zero.
                nxt.frac = frac_rnd[FRAC_W-1:0];
            end
        end else if (all_zero) begin
            nxt.zero = 1'b1;
        end else if (shift_ext >= exp_max) begin
            nxt.zero = 1'b1;
            nxt.unf  = 1'b1;
        end else begin
            nxt.exp  = exp_max - shift_ext;
            nxt.frac = frac_shift[FRAC_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            res_q     <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                res_q <= nxt;
            end
        end
    end

    assign exp_out      = res_q.exp;
    assign fraction_out = res_q.frac;
    assign zero_out     = res_q.zero;
    assign ovf_out      = res_q.ovf;
    assign unf_out      = res_q.unf;

endmodule

// File: tb/tb_fp_norm.sv
// tb/tb_fp_norm.sv - scoreboard bench for fp_norm with directed and random normalizer vectors
module tb_fp_norm;

    typedef struct packed {
        logic [7:0]  e;
        logic [22:0] f;
        logic        z;
        logic        o;
        logic        u;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  exp_max;
    logic [24:0] fraction_25;
    logic        out_valid;
    logic [7:0]  exp_out;
    logic [22:0] fraction_out;
    logic        zero_out;
    logic        ovf_out;
    logic        unf_out;

    res_t sb[$];
    res_t last_exp;
    int   errors = 0;
    int   checks = 0;

    fp_norm dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .exp_max      (exp_max),
        .fraction_25  (fraction_25),
        .out_valid    (out_valid),
        .exp_out      (exp_out),
        .fraction_out (fraction_out),
        .zero_out     (zero_out),
        .ovf_out      (ovf_out),
        .unf_out      (unf_out)
    );

    always #5 clk = ~clk;

    function automatic res_t observed();
        res_t r;
        r = {exp_out, fraction_out, zero_out, ovf_out, unf_out};
        return r;
    endfunction

    // Reference normalizer: shifts one bit at a time instead of counting zeros.
    function automatic res_t model(input logic [7:0] em, input logic [24:0] fr);
        res_t        r;
        int          ex;
        int          sh;
        logic [23:0] m;
        r = '0;
        if (fr == 25'd0) begin
            r.z = 1'b1;
        end else if (fr[24]) begin
            ex = int'(em) + 1;
            m  = {1'b0, fr[23:1]};
`ifdef FP_NORM_ROUND_EN
            if (fr[0] && fr[1]) m = m + 24'd1;
`endif
            if (m[23]) begin
                ex = ex + 1;
                m  = 24'd0;
            end
            if (ex >= 255) begin
                r.e = 8'd255;
                r.o = 1'b1;
            end else begin
                r.e = 8'(ex);
                r.f = m[22:0];
            end
        end else begin
            m  = fr[23:0];
            sh = 0;
            while (!m[23]) begin
                m  = m << 1;
                sh = sh + 1;
            end
            if (sh >= int'(em)) begin
                r.z = 1'b1;
                r.u = 1'b1;
            end else begin
                r.e = 8'(int'(em) - sh);
                r.f = m[22:0];
            end
        end
        return r;
    endfunction

    // Advance one edge and compare whatever the DUT presents against the scoreboard.
    task automatic tick();
        res_t e;
        res_t o;
        @(posedge clk);
        #1;
        o = observed();
        if (out_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                assert (1'b0) else begin
                    errors++;
                    $error("FAIL unexpected_out obs=%h exp=<none>", o);
                end
            end else begin
                e = sb.pop_front();
                last_exp = e;
                assert (o === e) else begin
                    errors++;
                    $error("FAIL result obs=%h exp=%h", o, e);
                end
            end
        end else if (sb.size() != 0) begin
            checks++;
            assert (1'b0) else begin
                errors++;
                $error("FAIL missing_out out_valid=%b exp=1", out_valid);
            end
            void'(sb.pop_front());
        end
    endtask

    task automatic send(input logic [7:0] em, input logic [24:0] fr, input res_t e);
        in_valid    = 1'b1;
        exp_max     = em;
        fraction_25 = fr;
        sb.push_back(e);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_model(input logic [7:0] em, input logic [24:0] fr);
        send(em, fr, model(em, fr));
    endtask

    task automatic idle_check();
        res_t o;
        in_valid    = 1'b0;
        exp_max     = 8'hA5;
        fraction_25 = 25'h0ABCDEF;
        tick();
        o = observed();
        checks++;
        assert (out_valid === 1'b0 && o === last_exp) else begin
            errors++;
            $error("FAIL hold obs=%b/%h exp=0/%h", out_valid, o, last_exp);
        end
    endtask

    task automatic reset_check();
        res_t o;
        rst_n       = 1'b0;
        in_valid    = 1'b1;
        exp_max     = 8'd200;
        fraction_25 = 25'h1555555;
        @(posedge clk);
        #1;
        o = observed();
        checks++;
        assert (out_valid === 1'b0 && o === res_t'(0)) else begin
            errors++;
            $error("FAIL reset obs=%b/%h exp=0/0", out_valid, o);
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        last_exp = '0;
    endtask

    res_t r;

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b1;
        exp_max     = 8'd7;
        fraction_25 = 25'h1FFFFFF;
        last_exp    = '0;
        @(posedge clk);
        #1;
        checks++;
        assert (out_valid === 1'b0 && observed() === res_t'(0)) else begin
            errors++;
            $error("FAIL reset_initial obs=%b/%h exp=0/0", out_valid, observed());
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        tick();

        r = '0; r.e = 8'd26;  r.f = 23'h6F96F9; send(8'd25,  25'b1110111110010110111110010, r);
        r = '0; r.e = 8'd24;  r.f = 23'h3E5BE4; send(8'd25,  25'b0010111110010110111110010, r);
        r = '0; r.e = 8'd25;  r.f = 23'h5F2DF2; send(8'd25,  25'b0110111110010110111110010, r);
        r = '0; r.e = 8'd122; r.f = 23'h796F90; send(8'd125, 25'b0000111110010110111110010, r);
        r = '0; r.e = 8'd126; r.f = 23'h1A6666; send(8'd125, 25'b1001101001100110011001101, r);
        idle_check();

        r = '0; r.z = 1'b1; send(8'd90, 25'd0, r);
        reset_check();
        r = '0; r.e = 8'd255; r.o = 1'b1; send(8'd254, 25'h1000000, r);
        reset_check();
        r = '0; r.z = 1'b1; r.u = 1'b1; send(8'd2, 25'h0000001, r);
        reset_check();

        r = '0; r.e = 8'd255; r.o = 1'b1; send(8'd255, 25'h1234567, r);
        r = '0; r.z = 1'b1; r.u = 1'b1; send(8'd1, 25'h0400000, r);
        r = '0; r.e = 8'd1; send(8'd2, 25'h0400000, r);
        send_model(8'd100, 25'h1FFFFFF);
        send_model(8'd253, 25'h1FFFFFF);
        send_model(8'd60,  25'h1000003);
        send_model(8'd30,  25'h0000001);
        idle_check();

        for (int k = 0; k < 24; k++) begin
            send_model(8'($urandom_range(0, 255)), 25'($urandom));
        end
        for (int k = 0; k < 8; k++) begin
            send_model(8'($urandom_range(0, 40)), 25'($urandom) >> $urandom_range(1, 24));
        end
        idle_check();

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain obs=%0d exp=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
